// File: rtl/mux4_rr_arbiter_if.sv
// Request/data/grant bundle between four requesters and the round-robin mux arbiter.
// The slave modport is the arbiter side; the master modport is the requester/consumer side.
interface mux4_rr_arbiter_if #(
  parameter int unsigned WIDTH = 1
);
  logic [3:0]       req;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  req, in0, in1, in2, in3,
    output gnt, sel, out_valid, out_data
  );

  modport master (
    output req, in0, in1, in2, in3,
    input  gnt, sel, out_valid, out_data
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4-to-1 mux, with a registered output.
// Optional macro ARB_HOLD_LIMIT_EN caps a grant at HOLD_MAX valid cycles while others wait.
module mux4_rr_arbiter #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned HOLD_MAX = 4
) (
  input logic               clk,
  input logic               reset,
  mux4_rr_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  if (HOLD_MAX < 1) begin : gen_bad_hold_max
    $error("HOLD_MAX must be >= 1");
  end

  state_e           state_q;
  logic [1:0]       last_q;
  logic [3:0]       gnt_q;
  logic [1:0]       sel_q;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  logic             found;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic [WIDTH-1:0] mux_data;
  logic             preempt;

  // Search starts just after the last served requester, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    mux_data = bus.in0;
    unique case (sel_q)
      2'd0: mux_data = bus.in0;
      2'd1: mux_data = bus.in1;
      2'd2: mux_data = bus.in2;
      2'd3: mux_data = bus.in3;
    endcase
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned CntW = $clog2(HOLD_MAX + 1);

  logic [CntW-1:0] hold_cnt_q;
  logic            others;

  assign others  = |(bus.req & ~(4'b0001 << sel_q));
  assign preempt = others && (hold_cnt_q == CntW'(HOLD_MAX));
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      last_q     <= 2'd3;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      valid_q    <= 1'b0;
      data_q     <= '0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          gnt_q   <= 4'b0000;
          valid_q <= 1'b0;
          if (found) begin
            gnt_q      <= 4'b0001 << win;
            sel_q      <= win;
            state_q    <= StBusy;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_q <= '0;
`endif
          end
        end
        StBusy: begin
          if (bus.req[sel_q] && !preempt) begin
            data_q  <= mux_data;
            valid_q <= 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
            if (hold_cnt_q != CntW'(HOLD_MAX)) hold_cnt_q <= hold_cnt_q + 1'b1;
`endif
          end else begin
            // Voluntary or forced release; sel and out_data keep their last values.
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
            last_q  <= sel_q;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (WIDTH=1, HOLD_MAX=2); hold-limit cases run only when
// ARB_HOLD_LIMIT_EN is defined, the no-preemption case only when it is not.
module tb_mux4_rr_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mux4_rr_arbiter_if #(.WIDTH(1)) bus ();

  mux4_rr_arbiter #(
    .WIDTH    (1),
    .HOLD_MAX (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic v, input logic d);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".data"}, 32'(bus.out_data), 32'(d));
  endtask

  task automatic do_reset(input logic [3:0] r);
    reset   = 1'b1;
    bus.req = r;
    step();
    reset   = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    bus.req = 4'b1111;
    bus.in0 = 1'b1;
    bus.in1 = 1'b0;
    bus.in2 = 1'b1;
    bus.in3 = 1'b0;

    // Reset held two cycles with all requesting.
    step();
    chk_out("rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_out("rst2", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_out("first_gnt", 4'b0001, 2'd0, 1'b0, 1'b0);

    // Single requester 2.
    do_reset(4'b0000);
    bus.req = 4'b0100;
    step();
    chk_out("r2_gnt", 4'b0100, 2'd2, 1'b0, 1'b0);
    step();
    chk_out("r2_valid", 4'b0100, 2'd2, 1'b1, 1'b1);
    bus.req = 4'b0000;
    step();
    chk_out("r2_rel", 4'b0000, 2'd2, 1'b0, 1'b1);
    step();
    chk_out("idle", 4'b0000, 2'd2, 1'b0, 1'b1);

`ifndef ARB_HOLD_LIMIT_EN
    // All requesting, no preemption: 0 holds until it drops, then 1 after a bubble.
    do_reset(4'b0000);
    bus.req = 4'b1111;
    step();
    chk_out("nl_g0", 4'b0001, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("nl_v0", 4'b0001, 2'd0, 1'b1, 1'b1);
    end
    bus.req = 4'b1110;
    step();
    chk_out("nl_bubble", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    chk_out("nl_g1", 4'b0010, 2'd1, 1'b0, 1'b1);
    step();
    chk_out("nl_v1", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.in1 = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_out("nl_hold1", 4'b0010, 2'd1, 1'b1, 1'b1);
    end
    bus.in1 = 1'b0;
`else
    // Hold limit 2 with all requesting: 0,1,2,3,0 each with exactly two valid cycles.
    bus.in2 = 1'b0;
    bus.in3 = 1'b1;
    do_reset(4'b0000);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] g;
      logic [1:0] s;
      logic       d;
      g = 4'b0001 << (k % 4);
      s = 2'(k % 4);
      d = (s == 2'd0) || (s == 2'd3);
      step();
      chk("hl_gnt", 32'(bus.gnt), 32'(g));
      chk("hl_gvalid", 32'(bus.out_valid), 32'd0);
      step();
      chk_out("hl_v1", g, s, 1'b1, d);
      step();
      chk_out("hl_v2", g, s, 1'b1, d);
      step();
      chk_out("hl_rel", 4'b0000, s, 1'b0, d);
    end

    // Lone requester 3 is never preempted.
    do_reset(4'b0000);
    bus.req = 4'b1000;
    step();
    chk_out("lone_g", 4'b1000, 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk_out("lone_v", 4'b1000, 2'd3, 1'b1, 1'b1);
    end
    bus.in2 = 1'b1;
    bus.in3 = 1'b0;
`endif

    // Reset while requester 1 holds a valid grant.
    do_reset(4'b0000);
    bus.in1 = 1'b1;
    bus.req = 4'b0010;
    step();
    step();
    chk_out("mid_busy", 4'b0010, 2'd1, 1'b1, 1'b1);
    reset   = 1'b1;
    bus.req = 4'b1111;
    step();
    chk_out("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_out("post_rst", 4'b0001, 2'd0, 1'b0, 1'b0);

    // Pointer wrap: after 0 is served, 3 outranks nothing; after 3, 0 is next.
    bus.req = 4'b1000;
    step();
    chk("wrap_rel0", 32'(bus.gnt), 32'h0);
    step();
    chk("wrap_g3", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0001;
    step();
    chk("wrap_rel3", 32'(bus.gnt), 32'h0);
    step();
    chk("wrap_g0", 32'(bus.gnt), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4-to-1 multiplexer datapath among four requesters.
It owns the mux select, issues a one-hot grant, and registers the selected input onto a single shared output with a valid flag.
It sits in front of the mux4_to_1 datapath and replaces static S1/S0 driving with a sequenced, fair select.

Parameters:
WIDTH, 1, data width of each input and of out_data
HOLD_MAX, 4, max consecutive valid cycles per grant when ARB_HOLD_LIMIT_EN is defined (must be >= 1)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  4  request per requester; req[i] high = requester i wants the mux
in0  input  WIDTH  requester 0 data
in1  input  WIDTH  requester 1 data
in2  input  WIDTH  requester 2 data
in3  input  WIDTH  requester 3 data
gnt  output  4  registered one-hot grant, 0000 when idle
sel  output  2  registered mux select {S1,S0}; encodes granted index
out_valid  output  1  registered; out_data holds granted requester's data
out_data  output  WIDTH  registered mux output

Behaviour:
- One clock (clk); reset synchronous, active-high, sampled on rising edge, dominates all other inputs.
- Reset values: gnt=0000, sel=00, out_valid=0, out_data=0, state=IDLE, last=3 (requester 0 has first priority), hold_cnt=0.
- States: IDLE, BUSY.
- IDLE, req=0000: all outputs hold reset-style idle values (gnt=0, out_valid=0); sel and out_data keep last values.
- IDLE, req!=0: winner = first i with req[i]=1, searching last+1, last+2, ... mod 4.
  - Same edge: gnt=onehot(winner), sel=winner, hold_cnt=0, state=BUSY; out_valid stays 0.
- BUSY, req[sel]=1 (hold): out_data<=in[sel], out_valid<=1, hold_cnt<=hold_cnt+1 (saturating).
- BUSY, req[sel]=0 (release): gnt<=0000, out_valid<=0, last<=sel, state<=IDLE. out_data and sel hold.
- Latency:
  - Request to grant: 1 edge.
  - Request to first out_valid: 2 edges.
  - Release to next grant: 1 idle bubble edge, then arbitration.
- Grant changes only in IDLE. Requests from non-granted requesters during BUSY are ignored until IDLE; no request is latched or queued.
- Simultaneous drop of granted req and rise of another: release first, new requester arbitrated on the following edge.
- Wrap-around: pointer order 0→1→2→3→0; with all four requesting continuously under hold-limit, grants cycle 0,1,2,3,0.
- Reset mid-BUSY: next edge returns to reset values; the in-flight grant is dropped without release bookkeeping (last=3).
- hold_cnt width: clog2(HOLD_MAX+1).

Optional Feature:
ARB_HOLD_LIMIT_EN
- Defined: in BUSY with req[sel]=1, if hold_cnt==HOLD_MAX and any req[j]=1 (j!=sel), the block force-releases exactly as a normal release (gnt=0, out_valid=0, last=sel, IDLE).
  - A granted requester therefore gets at most HOLD_MAX valid cycles while others wait.
  - With no competing request, the grant continues and hold_cnt saturates.
- Undefined: no preemption; the grant is held until the requester drops req; hold_cnt logic is omitted.

Test Plan:
1. Reset held 2 cycles with req=1111 → gnt=0000, sel=00, out_valid=0, out_data=0 throughout; after release, first grant goes to requester 0 (gnt=0001).
2. WIDTH=1; in0=1, in1=0, in2=1, in3=0; req=0100 from cycle 0 → edge1 gnt=0100, sel=10; edge2 out_valid=1, out_data=1. Drop req → next edge gnt=0000, out_valid=0.
3. req=1111 held; macro undefined; requester 0 drops after 3 valid cycles → grants observed in order 0 then 1 (one bubble between), never 0 twice in a row.
4. ARB_HOLD_LIMIT_EN, HOLD_MAX=2, req=1111 constant → each grant yields exactly 2 valid cycles; gnt sequence 0001,0010,0100,1000,0001.
5. ARB_HOLD_LIMIT_EN, HOLD_MAX=2, only req[3]=1 → grant 1000 held with out_valid=1 for 10+ cycles; no preemption.
6. Mid-BUSY (gnt=0010, out_valid=1), assert reset 1 cycle with req=1111 → next edge all reset values; after reset, gnt=0001.
